// File: rtl/accum_sat_n_bits_pkg.sv
// ----------------------------------------------------------------------------
// accum_sat_n_bits_pkg
// Shared constants for the accumulator block.
//   OP_ADD  : acc <= acc + din
//   OP_SUB  : acc <= acc - din  (done as acc + ~din + 1)
//   OP_LOAD : acc <= din, counter restarts, sticky overflow kept
//   OP_CLR  : acc and every flag back to zero
// ----------------------------------------------------------------------------
package accum_sat_n_bits_pkg;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_LOAD = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;

endpackage

// File: rtl/accum_sat_n_bits_rca.sv
// ----------------------------------------------------------------------------
// ripple_carry_adder
// Plain N-bit ripple-carry adder: sum = a + b + cin, cout = carry out of MSB.
// Ports:
//   a, b  : N-bit operands
//   cin   : carry in
//   sum   : N-bit result
//   cout  : carry out of bit N-1
// ----------------------------------------------------------------------------
module ripple_carry_adder #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    // The ripple carry is held in a block-local variable so the chain is
    // evaluated bit by bit inside one process.
    always_comb begin
        logic carry;
        carry = cin;
        sum   = '0;
        for (int i = 0; i < N; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/accum_sat_n_bits.sv
// ----------------------------------------------------------------------------
// accum_sat_n_bits
// Two-stage accumulator with optional signed saturation.
// Stage 1 registers the request (en/op/din); stage 2 applies it to acc and
// the flags on the following edge, so a request sampled at edge k shows on
// acc after edge k+1. One operation per cycle; every add/sub reads the acc
// left by the immediately preceding operation.
// Ports:
//   clk        : rising-edge clock
//   aclr       : asynchronous active-low reset (clears both stages)
//   en         : operation request
//   op         : 00 add, 01 sub, 10 load, 11 clear
//   din        : N-bit two's complement operand
//   acc        : accumulator value
//   carry      : unsigned carry-out of last add/sub (sub: 1 = no borrow)
//   ovf        : signed overflow of last add/sub
//   ovf_sticky : any overflow since last clear/reset
//   count      : add/sub operations since last clear/load (wraps)
//   cnt_wrap   : one-cycle pulse after count steps from all-ones to zero
// ----------------------------------------------------------------------------
module accum_sat_n_bits
    import accum_sat_n_bits_pkg::*;
#(
    parameter int N     = 8,
    parameter int SAT   = 0,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             aclr,
    input  logic             en,
    input  logic [1:0]       op,
    input  logic [N-1:0]     din,
    output logic [N-1:0]     acc,
    output logic             carry,
    output logic             ovf,
    output logic             ovf_sticky,
    output logic [CNT_W-1:0] count,
    output logic             cnt_wrap
);

    // Stage 1: registered request
    logic             en_s1_q,  en_s1_d;
    logic [1:0]       op_s1_q,  op_s1_d;
    logic [N-1:0]     din_s1_q, din_s1_d;

    // Stage 2: architectural state
    logic [N-1:0]     acc_q,        acc_d;
    logic             carry_q,      carry_d;
    logic             ovf_q,        ovf_d;
    logic             ovf_sticky_q, ovf_sticky_d;
    logic [CNT_W-1:0] count_q,      count_d;
    logic             cnt_wrap_q,   cnt_wrap_d;

    // Adder datapath
    logic [N-1:0]     add_b;
    logic             add_cin;
    logic [N-1:0]     add_sum;
    logic             add_cout;
    logic             add_ovf;
    logic [N-1:0]     sat_val;
    logic             is_addsub;

    always_comb begin
        en_s1_d  = en;
        op_s1_d  = op;
        din_s1_d = din;
    end

    // Subtraction reuses the adder as acc + ~din + 1.
    always_comb begin
        add_cin = (op_s1_q == OP_SUB);
        add_b   = add_cin ? ~din_s1_q : din_s1_q;
    end

    ripple_carry_adder #(
        .N (N)
    ) u_adder (
        .a    (acc_q),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Signed overflow: operands agree in sign but the result does not.
    always_comb begin
        add_ovf   = (acc_q[N-1] == add_b[N-1]) && (add_sum[N-1] != acc_q[N-1]);
        sat_val   = acc_q[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        is_addsub = en_s1_q && ((op_s1_q == OP_ADD) || (op_s1_q == OP_SUB));
    end

    always_comb begin
        acc_d        = acc_q;
        carry_d      = carry_q;
        ovf_d        = ovf_q;
        ovf_sticky_d = ovf_sticky_q;
        count_d      = count_q;
        cnt_wrap_d   = 1'b0;

        if (en_s1_q) begin
            case (op_s1_q)
                OP_LOAD: begin
                    acc_d   = din_s1_q;
                    carry_d = 1'b0;
                    ovf_d   = 1'b0;
                    count_d = '0;
                end
                OP_CLR: begin
                    acc_d        = '0;
                    carry_d      = 1'b0;
                    ovf_d        = 1'b0;
                    ovf_sticky_d = 1'b0;
                    count_d      = '0;
                end
                default: begin
                    acc_d   = ((SAT != 0) && add_ovf) ? sat_val : add_sum;
                    carry_d = add_cout;
                    ovf_d   = add_ovf;
                    if (add_ovf) begin
                        ovf_sticky_d = 1'b1;
                    end
                end
            endcase
        end

        if (is_addsub) begin
            count_d    = count_q + CNT_W'(1);
            cnt_wrap_d = &count_q;
        end
    end

    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            en_s1_q      <= 1'b0;
            op_s1_q      <= 2'b00;
            din_s1_q     <= '0;
            acc_q        <= '0;
            carry_q      <= 1'b0;
            ovf_q        <= 1'b0;
            ovf_sticky_q <= 1'b0;
            count_q      <= '0;
            cnt_wrap_q   <= 1'b0;
        end else begin
            en_s1_q      <= en_s1_d;
            op_s1_q      <= op_s1_d;
            din_s1_q     <= din_s1_d;
            acc_q        <= acc_d;
            carry_q      <= carry_d;
            ovf_q        <= ovf_d;
            ovf_sticky_q <= ovf_sticky_d;
            count_q      <= count_d;
            cnt_wrap_q   <= cnt_wrap_d;
        end
    end

    assign acc        = acc_q;
    assign carry      = carry_q;
    assign ovf        = ovf_q;
    assign ovf_sticky = ovf_sticky_q;
    assign count      = count_q;
    assign cnt_wrap   = cnt_wrap_q;

endmodule
